// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
package fetch_pkg;

   // One buffered fetch: the PC and the instruction word fetched from it.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // addi x0,x0,0; decode substitutes this when no entry is valid.
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Wrapping FIFO pointer; clear has priority over increment.
module fetch_buffer_ptr #(
   parameter int PTR_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   // Power-of-two depth lets the natural overflow provide the wrap.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         o_ptr <= '0;
      end else if (i_inc) begin
         o_ptr <= o_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Circular buffer of {pc, inst} pairs between fetch and decode, with flush.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [31:0]      i_pc,
   input  logic [31:0]      i_inst,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_inst,
   output logic [PTR_W:0]   o_count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push;
   logic             pop;

   // Handshake flags come from registered count only, so a full buffer never
   // accepts on the strength of a same-cycle pop.
   assign o_ready = (count != FULL_CNT);
   assign o_valid = (count != '0);
   assign o_count = count;

   assign push = i_valid & o_ready & ~i_flush;
   assign pop  = o_valid & i_ready & ~i_flush;

   fetch_buffer_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (i_flush),
      .i_inc (push),
      .o_ptr (wr_ptr)
   );

   fetch_buffer_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (i_flush),
      .i_inc (pop),
      .o_ptr (rd_ptr)
   );

   // Storage write; contents are not reset, occupancy alone qualifies them.
   always_ff @(posedge i_clk) begin
      if (!i_rst && push) begin
         mem[wr_ptr] <= '{pc: i_pc, inst: i_inst};
      end
   end

   // Occupancy tracking; reset and flush both empty the buffer.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head presentation, forced to zero while nothing is buffered.
   always_comb begin
      o_pc   = '0;
      o_inst = '0;
      if (o_valid) begin
         o_pc   = mem[rd_ptr].pc;
         o_inst = mem[rd_ptr].inst;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;

   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready_dut;
   logic [31:0]      pc = '0;
   logic [31:0]      inst = '0;
   logic             out_valid;
   logic             dec_ready = 1'b0;
   logic [31:0]      out_pc;
   logic [31:0]      out_inst;
   logic [PTR_W:0]   out_count;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] q[$];

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .i_valid (in_valid),
      .o_ready (out_ready_dut),
      .i_pc    (pc),
      .i_inst  (inst),
      .o_valid (out_valid),
      .i_ready (dec_ready),
      .o_pc    (out_pc),
      .o_inst  (out_inst),
      .o_count (out_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] head;
      head = (q.size() != 0) ? q[0] : 64'h0;
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      chk("ready", 32'(out_ready_dut), 32'(q.size() != DEPTH));
      chk("count", 32'(out_count), 32'(q.size()));
      chk("pc",    out_pc,   head[63:32]);
      chk("inst",  out_inst, head[31:0]);
      chk("no_push_when_full", 32'(out_ready_dut && out_count == DEPTH), 32'h0);
   endtask

   // One clock: drive inputs, step the model by the buffer rules, check.
   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [31:0] p, input logic [31:0] ins,
                      input logic rdy, output logic accepted);
      logic do_push, do_pop;
      rst = r; flush = f; in_valid = v; pc = p; inst = ins; dec_ready = rdy;
      do_push = v && (q.size() != DEPTH) && !f;
      do_pop  = (q.size() != 0) && rdy && !f;
      @(posedge clk);
      #1;
      accepted = do_push && !r;
      if (r || f) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({p, ins});
      end
      check_outputs();
   endtask

   initial begin
      logic acc;
      logic [31:0] ppc;
      logic [31:0] pinst;

      // Reset then idle
      cyc(1, 0, 0, 32'h0, 32'h0, 0, acc);
      cyc(1, 0, 0, 32'h0, 32'h0, 0, acc);
      cyc(0, 0, 0, 32'h0, 32'h0, 0, acc);

      // Single pass
      cyc(0, 0, 1, 32'h0, 32'h0050_0093, 1, acc);
      chk("single_head_pc", out_pc, 32'h0);
      cyc(0, 0, 0, 32'h0, 32'h0, 1, acc);
      chk("single_drain", 32'(out_count), 32'h0);

      // Fill and stall, then refused entry and in-order drain
      for (int n = 0; n < 4; n++)
         cyc(0, 0, 1, 32'(4 * n), 32'h1000 + 32'(n), 0, acc);
      cyc(0, 0, 1, 32'h10, 32'h1010, 0, acc);
      chk("full_refuse", 32'(acc), 32'h0);
      chk("full_head", out_pc, 32'h0);
      cyc(0, 0, 1, 32'h10, 32'h1010, 1, acc);
      chk("full_pop_only", 32'(acc), 32'h0);
      cyc(0, 0, 1, 32'h10, 32'h1010, 1, acc);
      chk("reoffer_accept", 32'(acc), 32'h1);
      for (int n = 0; n < 5; n++)
         cyc(0, 0, 0, 32'h0, 32'h0, 1, acc);

      // Wrap-around under streaming
      for (int n = 0; n < 3 * DEPTH; n++) begin
         cyc(0, 0, 1, 32'(4 * n), $urandom, 1, acc);
         chk("stream_pc", out_pc, 32'(4 * n));
         chk("stream_count", 32'(out_count), 32'h1);
      end
      cyc(0, 0, 0, 32'h0, 32'h0, 1, acc);

      // Flush mid-stream
      for (int n = 0; n < 3; n++)
         cyc(0, 0, 1, 32'h20 + 32'(4 * n), $urandom, 0, acc);
      cyc(0, 1, 1, 32'h40, 32'h4040, 1, acc);
      chk("flush_empty", 32'(out_count), 32'h0);
      cyc(0, 0, 1, 32'h80, 32'h8080, 0, acc);
      chk("flush_next_head", out_pc, 32'h80);

      // Reset mid-operation with simultaneous push, pop and flush
      cyc(0, 1, 0, 32'h0, 32'h0, 0, acc);
      for (int n = 0; n < DEPTH; n++)
         cyc(0, 0, 1, 32'h100 + 32'(4 * n), $urandom, 0, acc);
      cyc(1, 1, 1, 32'h200, 32'h2020, 1, acc);
      chk("rst_pc_zero", out_pc, 32'h0);
      cyc(0, 0, 0, 32'h0, 32'h0, 1, acc);

      // Randomized traffic; producer holds its entry until accepted
      ppc = 32'h1000;
      pinst = $urandom;
      for (int n = 0; n < 400; n++) begin
         logic r, f, v, rd;
         r  = ($urandom_range(0, 59) == 0);
         f  = ($urandom_range(0, 19) == 0);
         v  = ($urandom_range(0, 9) < 7);
         rd = ($urandom_range(0, 9) < 5);
         cyc(r, f, v, ppc, pinst, rd, acc);
         if (acc) begin
            ppc   = ppc + 32'h4;
            pinst = $urandom;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Consumes the fetch stream produced by the program counter: each cycle's fetch PC plus the instruction word returned by instruction memory.
- Buffers up to DEPTH {pc, inst} pairs in a circular FIFO.
- Presents them in order to decode over a valid/ready handshake, decoupling fetch from decode stalls.
- Supports a single-cycle flush for branch/jump redirects.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst  input  1  reset, synchronous, active-high.
- i_flush  input  1  redirect; discards all buffered entries.
- i_valid  input  1  fetch side has a valid {pc, inst} this cycle.
- o_ready  output  1  buffer can accept a fetch-side entry this cycle.
- i_pc  input  32  fetch PC.
- i_inst  input  32  instruction word for i_pc.
- o_valid  output  1  head entry available to decode.
- i_ready  input  1  decode accepts the head entry this cycle.
- o_pc  output  32  head entry PC.
- o_inst  output  32  head entry instruction.
- o_count  output  PTR_W+1  number of occupied entries, 0..DEPTH.

Behaviour:
- State:
  - wr_ptr, rd_ptr: PTR_W bits each, wrap modulo DEPTH.
  - count: PTR_W+1 bits.
  - Storage: DEPTH x 64 bits.
- Reset (i_rst=1 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Next cycle: o_valid=0, o_ready=1, o_count=0, o_pc=0, o_inst=0.
  - Storage contents are not reset.
- Reset has priority over flush, push and pop.
- Push = i_valid & o_ready & !i_flush.
  - Writes {i_pc, i_inst} at wr_ptr.
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop = o_valid & i_ready & !i_flush.
  - rd_ptr increments with the same wrap.
- Count:
  - Push & Pop: count unchanged.
  - Push only: count+1.
  - Pop only: count-1.
- Outputs:
  - o_ready = (count != DEPTH). Combinational from registered state only; no dependence on i_ready, so there is no write-through when full.
  - o_valid = (count != 0). Registered-state derived; no bypass from input to output, so minimum latency is 1 cycle.
  - o_pc/o_inst = storage[rd_ptr] when o_valid=1, else 32'h0 each.
  - o_count = count.
- Full: simultaneous i_valid=1 and i_ready=1 gives a pop only. The new entry is refused (o_ready=0) and must be held by the producer.
- Empty: i_ready is ignored. A push in the same cycle becomes visible at the next cycle.
- Flush (i_flush=1, i_rst=0):
  - Next cycle: wr_ptr=0, rd_ptr=0, count=0.
  - Any push or pop offered in the flush cycle is discarded.
  - o_ready is unaffected in the flush cycle.
- Handshake rules:
  - Producer holds i_pc/i_inst stable while i_valid=1 and o_ready=0.
  - Head outputs remain stable while o_valid=1 and i_ready=0.
- Ordering: entries leave in exactly the order accepted. No duplication, no loss except on flush or reset.
- Assertions (bench): count <= DEPTH; o_valid implies count > 0; no push when count == DEPTH.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_entry_t = struct {pc[31:0], inst[31:0]}.
  - Constant NOP_INST = 32'h00000013, used by decode when o_valid=0; this block does not insert it.
- One natural sub-module: fetch_buffer_ptr, a wrapping PTR_W-bit pointer with inc and clear inputs, instantiated twice (write and read).
- Storage, count and handshake logic stay in fetch_buffer.

Test Plan:
- Reset then idle:
  - Stimulus: hold i_rst for 2 cycles.
  - Required: o_valid=0, o_ready=1, o_count=0, o_pc=0, o_inst=0.
- Single pass:
  - Stimulus: push pc=0x0 inst=0x00500093 with i_ready=1.
  - Required: o_valid=1 the next cycle with the same pc/inst, then o_count returns to 0.
- Fill and stall:
  - Stimulus: i_ready=0; push pc=0x0,0x4,0x8,0xC, then attempt 0x10.
  - Required: o_count=4, o_ready=0; 0x10 not accepted; head stays pc=0x0.
  - Then raise i_ready: entries exit in order 0x0,0x4,0x8,0xC, then 0x10 after re-offer.
- Wrap-around under streaming:
  - Stimulus: 3*DEPTH consecutive pushes (pc=4n) with i_ready=1 every cycle.
  - Required: all pcs exit in order with 1-cycle latency; o_count stays 1 in steady state; pointers wrap without loss.
- Flush mid-stream:
  - Stimulus: 3 entries buffered; assert i_flush with i_valid=1 pc=0x40 and i_ready=1.
  - Required: next cycle o_valid=0, o_count=0; pc=0x40 not stored; the next push pc=0x80 appears as head.
- Reset mid-operation:
  - Stimulus: i_rst with DEPTH entries buffered plus a simultaneous push, pop and flush.
  - Required: next cycle empty, o_ready=1, o_pc=0; no stale entry ever appears at the output.
